// File: rtl/fft_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fft_pkg : shared FFT sequencer types and address helper functions          |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package fft_pkg;

    localparam int FFT_MAX_N = 16;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LOAD       = 3'd1,
        ST_STAGE      = 3'd2,
        ST_DRAIN      = 3'd3,
        ST_UNLOAD_RD  = 3'd4,
        ST_UNLOAD_VLD = 3'd5
    } fft_state_e;

    typedef enum logic [1:0] {
        MEM_A = 2'd0,
        MEM_B = 2'd1,
        MEM_O = 2'd2
    } fft_mem_e;

    function automatic int unsigned fft_bitrev(input int unsigned x, input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < FFT_MAX_N; i++) begin
            if (i < n && ((x >> i) & 32'd1) != 0)
                r = r | (32'd1 << (n - 1 - i));
        end
        return r;
    endfunction

    function automatic int unsigned fft_span(input int unsigned n, input int unsigned s);
        return 32'd1 << (n - 1 - s);
    endfunction

    function automatic int unsigned fft_bf_addr0(input int unsigned n, input int unsigned s,
                                                 input int unsigned k);
        return ((k >> (n - 1 - s)) << (n - s)) | (k & (fft_span(n, s) - 1));
    endfunction

    function automatic int unsigned fft_tw_addr(input int unsigned n, input int unsigned s,
                                                input int unsigned k);
        return (k & (fft_span(n, s) - 1)) << s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_addr_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fft_addr_gen : (stage, butterfly) -> butterfly pair and twiddle addresses  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module fft_addr_gen
    import fft_pkg::*;
#(
    parameter int N = 4
)(
    input  logic [$clog2(N)-1:0] stage_i,
    input  logic [N-2:0]         k_i,
    output logic [N-1:0]         addr0_o,
    output logic [N-1:0]         addr1_o,
    output logic [N-1:0]         addr_crom_o
);

    assign addr0_o     = N'(fft_bf_addr0(N, 32'(stage_i), 32'(k_i)));
    assign addr1_o     = N'(fft_bf_addr0(N, 32'(stage_i), 32'(k_i)) + fft_span(N, 32'(stage_i)));
    assign addr_crom_o = N'(fft_tw_addr(N, 32'(stage_i), 32'(k_i)));

endmodule
`default_nettype wire

// File: rtl/fft_mem_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fft_mem_sequencer : load / stage / unload control for the ping-pong FFT    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module fft_mem_sequencer
    import fft_pkg::*;
#(
    parameter int N      = 4,
    parameter int RD_LAT = 1,
    parameter int BF_LAT = 2
)(
    input  logic         clk,
    input  logic         rstn,
    input  logic         in_vld,
    input  logic         out_rdy,
    output logic         in_rdy,
    output logic         out_vld,
    output logic         sel_input,
    output logic         we_AMEM,
    output logic         we_BMEM,
    output logic         we_OMEM,
    output logic [N-1:0] addr0_AMEM,
    output logic [N-1:0] addr1_AMEM,
    output logic [N-1:0] addr0_BMEM,
    output logic [N-1:0] addr1_BMEM,
    output logic [N-1:0] addr0_OMEM,
    output logic [N-1:0] addr1_OMEM,
    output logic [N-1:0] addr_CROM,
    output logic         bf_vld,
    output logic         busy
);

    localparam int HALF = 1 << (N - 1);
    localparam int DLY  = RD_LAT + BF_LAT;
    localparam int SW   = $clog2(N);
    localparam int KW   = N - 1;
    localparam int CW   = $clog2(DLY + RD_LAT + 1);

    typedef struct packed {
        logic           vld;
        fft_mem_e       mem;
        logic [N-1:0]   a0;
        logic [N-1:0]   a1;
    } wr_t;

    fft_state_e    state_q, state_d;
    logic [SW-1:0] s_q, s_d;
    logic [KW-1:0] k_q, k_d;
    logic [KW-1:0] j_q, j_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [N-1:0]  rd_a0, rd_a1, rd_crom;
    logic          issue;
    fft_mem_e      src_mem, dst_mem;
    wr_t           wr_in, wr_out;
    wr_t           dl_q [DLY];
    logic [RD_LAT:0] rv_q;

    logic          in_rdy_q, sel_input_q, busy_q, out_vld_q;
    logic          we_a_q, we_b_q, we_o_q;
    logic [N-1:0]  a0_a_q, a1_a_q, a0_b_q, a1_b_q, a0_o_q, a1_o_q, crom_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            s_q     <= '0;
            k_q     <= '0;
            j_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            k_q     <= k_d;
            j_q     <= j_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        k_d     = k_q;
        j_d     = j_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                state_d = ST_LOAD;
                j_d     = '0;
            end
            ST_LOAD: begin
                if (in_vld) begin
                    if (j_q == KW'(HALF - 1)) begin
                        state_d = ST_STAGE;
                        s_d     = '0;
                        k_d     = '0;
                    end else begin
                        j_d = j_q + 1'b1;
                    end
                end
            end
            ST_STAGE: begin
                if (k_q == KW'(HALF - 1)) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                // Hold off the next stage until every in-flight write has landed.
                if (cnt_q == CW'(DLY - 1)) begin
                    k_d   = '0;
                    cnt_d = '0;
                    if (s_q == SW'(N - 1)) begin
                        state_d = ST_UNLOAD_RD;
                        j_d     = '0;
                    end else begin
                        state_d = ST_STAGE;
                        s_d     = s_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_UNLOAD_RD: begin
                if (cnt_q == CW'(RD_LAT - 1))
                    state_d = ST_UNLOAD_VLD;
                else
                    cnt_d = cnt_q + 1'b1;
            end
            ST_UNLOAD_VLD: begin
                if (out_rdy) begin
                    cnt_d = '0;
                    if (j_q == KW'(HALF - 1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        j_d     = j_q + 1'b1;
                        state_d = ST_UNLOAD_RD;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Addresses are generated from next-state so the registered outputs line up with state_q.
    fft_addr_gen #(.N(N)) u_addr_gen (
        .stage_i     (s_d),
        .k_i         (k_d),
        .addr0_o     (rd_a0),
        .addr1_o     (rd_a1),
        .addr_crom_o (rd_crom)
    );

    assign issue   = (state_d == ST_STAGE);
    assign src_mem = s_d[0] ? MEM_B : MEM_A;
    assign dst_mem = (s_d == SW'(N - 1)) ? MEM_O : (s_d[0] ? MEM_A : MEM_B);
    assign wr_in   = '{vld: issue, mem: dst_mem, a0: rd_a0, a1: rd_a1};
    assign wr_out  = dl_q[DLY-1];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DLY; i++) dl_q[i] <= '0;
            rv_q <= '0;
        end else begin
            dl_q[0] <= wr_in;
            for (int i = 1; i < DLY; i++) dl_q[i] <= dl_q[i-1];
            rv_q <= {rv_q[RD_LAT-1:0], issue};
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            in_rdy_q    <= 1'b0;
            sel_input_q <= 1'b0;
            busy_q      <= 1'b0;
            out_vld_q   <= 1'b0;
            we_a_q      <= 1'b1;
            we_b_q      <= 1'b1;
            we_o_q      <= 1'b1;
            a0_a_q      <= '0;
            a1_a_q      <= '0;
            a0_b_q      <= '0;
            a1_b_q      <= '0;
            a0_o_q      <= '0;
            a1_o_q      <= '0;
            crom_q      <= '0;
        end else begin
            in_rdy_q    <= (state_d == ST_LOAD);
            sel_input_q <= (state_d == ST_LOAD);
            busy_q      <= !(state_d inside {ST_IDLE, ST_LOAD});
            out_vld_q   <= (state_d == ST_UNLOAD_VLD);
            we_a_q      <= !(wr_out.vld && wr_out.mem == MEM_A);
            we_b_q      <= !(wr_out.vld && wr_out.mem == MEM_B);
            we_o_q      <= !(wr_out.vld && wr_out.mem == MEM_O);
            if (state_d == ST_LOAD) begin
                a0_a_q <= {j_d, 1'b0};
                a1_a_q <= {j_d, 1'b1};
            end
            if (issue) begin
                crom_q <= rd_crom;
                if (src_mem == MEM_A) begin
                    a0_a_q <= rd_a0;
                    a1_a_q <= rd_a1;
                end else begin
                    a0_b_q <= rd_a0;
                    a1_b_q <= rd_a1;
                end
            end
            if (state_d == ST_UNLOAD_RD || state_d == ST_UNLOAD_VLD) begin
                a0_o_q <= N'(fft_bitrev(32'({j_d, 1'b0}), N));
                a1_o_q <= N'(fft_bitrev(32'({j_d, 1'b1}), N));
            end
            if (wr_out.vld) begin
                case (wr_out.mem)
                    MEM_A:   begin a0_a_q <= wr_out.a0; a1_a_q <= wr_out.a1; end
                    MEM_B:   begin a0_b_q <= wr_out.a0; a1_b_q <= wr_out.a1; end
                    default: begin a0_o_q <= wr_out.a0; a1_o_q <= wr_out.a1; end
                endcase
            end
        end
    end

    // LOAD write enable follows in_vld in the same cycle; everything else is registered.
    assign we_AMEM    = (state_q == ST_LOAD) ? !in_vld : we_a_q;
    assign we_BMEM    = we_b_q;
    assign we_OMEM    = we_o_q;
    assign in_rdy     = in_rdy_q;
    assign sel_input  = sel_input_q;
    assign busy       = busy_q;
    assign out_vld    = out_vld_q;
    assign bf_vld     = rv_q[RD_LAT];
    assign addr0_AMEM = a0_a_q;
    assign addr1_AMEM = a1_a_q;
    assign addr0_BMEM = a0_b_q;
    assign addr1_BMEM = a1_b_q;
    assign addr0_OMEM = a0_o_q;
    assign addr1_OMEM = a1_o_q;
    assign addr_CROM  = crom_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_mem_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fft_mem_sequencer : scoreboard bench for the FFT memory sequencer       |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_fft_mem_sequencer;

    localparam int N       = 4;
    localparam int RD_LAT  = 1;
    localparam int BF_LAT  = 2;
    localparam int HALF    = 1 << (N - 1);
    localparam int DLY     = RD_LAT + BF_LAT;
    localparam int COMPUTE = N * (HALF + DLY);

    logic clk = 1'b0;
    logic rstn, in_vld, out_rdy;
    logic in_rdy, out_vld, sel_input, we_AMEM, we_BMEM, we_OMEM, bf_vld, busy;
    logic [N-1:0] addr0_AMEM, addr1_AMEM, addr0_BMEM, addr1_BMEM;
    logic [N-1:0] addr0_OMEM, addr1_OMEM, addr_CROM;

    always #5 clk = ~clk;

    fft_mem_sequencer #(.N(N), .RD_LAT(RD_LAT), .BF_LAT(BF_LAT)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_vld     (in_vld),
        .out_rdy    (out_rdy),
        .in_rdy     (in_rdy),
        .out_vld    (out_vld),
        .sel_input  (sel_input),
        .we_AMEM    (we_AMEM),
        .we_BMEM    (we_BMEM),
        .we_OMEM    (we_OMEM),
        .addr0_AMEM (addr0_AMEM),
        .addr1_AMEM (addr1_AMEM),
        .addr0_BMEM (addr0_BMEM),
        .addr1_BMEM (addr1_BMEM),
        .addr0_OMEM (addr0_OMEM),
        .addr1_OMEM (addr1_OMEM),
        .addr_CROM  (addr_CROM),
        .bf_vld     (bf_vld),
        .busy       (busy)
    );

    typedef struct {
        int mem;
        int a0;
        int a1;
        int crom;
    } exp_t;

    exp_t q_load [$];
    exp_t q_rd   [$];
    exp_t q_wr   [$];
    exp_t q_out  [$];
    int   q_iss  [$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_load_wr = 0;
    int n_out_hs  = 0;
    int first_iss = -1;
    int last_hs   = -1;
    bit seen_out  = 1'b0;
    int rdy_mode  = 0;
    int prev_a [3][2];
    int prev_crom = 0;
    bit prev_out_vld = 1'b0;
    bit prev_out_rdy = 1'b0;

    task automatic chk(input string tag, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic int m_bitrev(input int x);
        int r;
        r = 0;
        for (int i = 0; i < N; i++)
            if (x[i]) r[N-1-i] = 1'b1;
        return r;
    endfunction

    function automatic int cur_addr(input int mem, input int port);
        case (mem)
            0:       return port == 0 ? int'(addr0_AMEM) : int'(addr1_AMEM);
            1:       return port == 0 ? int'(addr0_BMEM) : int'(addr1_BMEM);
            default: return port == 0 ? int'(addr0_OMEM) : int'(addr1_OMEM);
        endcase
    endfunction

    // Expected compute and unload traffic of one frame, straight from the address equations.
    task automatic push_frame_exp();
        exp_t e;
        int span, a0;
        for (int s = 0; s < N; s++) begin
            span = 1 << (N - 1 - s);
            for (int k = 0; k < HALF; k++) begin
                a0 = ((k >> (N - 1 - s)) << (N - s)) | (k & (span - 1));
                e.mem = (s % 2 == 1) ? 1 : 0;
                e.a0 = a0; e.a1 = a0 + span; e.crom = (k & (span - 1)) << s;
                q_rd.push_back(e);
                e.mem = (s == N - 1) ? 2 : ((s % 2 == 1) ? 0 : 1);
                e.crom = 0;
                q_wr.push_back(e);
            end
        end
        for (int j = 0; j < HALF; j++) begin
            e.mem = 2; e.a0 = m_bitrev(2 * j); e.a1 = m_bitrev(2 * j + 1); e.crom = 0;
            q_out.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        int wr_mem, nlow, iss;
        cyc++;
        if (!rstn) begin
            q_load.delete(); q_rd.delete(); q_wr.delete(); q_out.delete(); q_iss.delete();
            prev_out_vld = 1'b0;
        end else begin
            if (sel_input) begin
                first_iss = -1; last_hs = -1; seen_out = 1'b0;
            end
            if (sel_input && !we_AMEM) begin
                n_load_wr++;
                if (q_load.size() == 0) chk("load_unexpected", 1, 0);
                else begin
                    e = q_load.pop_front();
                    chk("load_a0", addr0_AMEM, e.a0);
                    chk("load_a1", addr1_AMEM, e.a1);
                end
            end
            if (bf_vld) begin
                if (first_iss < 0) first_iss = cyc - RD_LAT;
                q_iss.push_back(cyc - RD_LAT);
                if (q_rd.size() == 0) chk("rd_unexpected", 1, 0);
                else begin
                    e = q_rd.pop_front();
                    chk("rd_a0", prev_a[e.mem][0], e.a0);
                    chk("rd_a1", prev_a[e.mem][1], e.a1);
                    chk("rd_crom", prev_crom, e.crom);
                end
            end
            wr_mem = -1; nlow = 0;
            if (!we_AMEM && !sel_input) begin wr_mem = 0; nlow++; end
            if (!we_BMEM) begin wr_mem = 1; nlow++; end
            if (!we_OMEM) begin wr_mem = 2; nlow++; end
            if (nlow > 1) chk("multi_we", nlow, 1);
            if (wr_mem >= 0) begin
                if (q_wr.size() == 0) chk("wr_unexpected", 1, 0);
                else begin
                    e = q_wr.pop_front();
                    chk("wr_mem", wr_mem, e.mem);
                    chk("wr_a0", cur_addr(wr_mem, 0), e.a0);
                    chk("wr_a1", cur_addr(wr_mem, 1), e.a1);
                end
                if (q_iss.size() == 0) chk("wr_no_issue", 1, 0);
                else begin
                    iss = q_iss.pop_front();
                    chk("wr_latency", cyc - iss, DLY);
                end
            end
            if (prev_out_vld && !prev_out_rdy) begin
                chk("out_vld_hold", out_vld, 1);
                chk("out_hold_a0", addr0_OMEM, prev_a[2][0]);
                chk("out_hold_a1", addr1_OMEM, prev_a[2][1]);
            end
            if (out_vld && !seen_out) begin
                seen_out = 1'b1;
                chk("first_out_latency", cyc - first_iss, COMPUTE + RD_LAT);
            end
            if (out_vld && out_rdy) begin
                if (rdy_mode == 0 && last_hs >= 0) chk("unload_spacing", cyc - last_hs, RD_LAT + 1);
                last_hs = cyc;
                n_out_hs++;
                if (q_out.size() == 0) chk("out_unexpected", 1, 0);
                else begin
                    e = q_out.pop_front();
                    chk("out_a0", addr0_OMEM, e.a0);
                    chk("out_a1", addr1_OMEM, e.a1);
                end
            end
            prev_a[0][0] = addr0_AMEM; prev_a[0][1] = addr1_AMEM;
            prev_a[1][0] = addr0_BMEM; prev_a[1][1] = addr1_BMEM;
            prev_a[2][0] = addr0_OMEM; prev_a[2][1] = addr1_OMEM;
            prev_crom    = addr_CROM;
            prev_out_vld = out_vld;
            prev_out_rdy = out_rdy;
        end
    end

    initial begin
        out_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1 out_rdy = (rdy_mode != 0) ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    task automatic chk_reset(input string tag);
        chk({tag, "_flags"}, 32'({in_rdy, out_vld, sel_input, we_AMEM, we_BMEM, we_OMEM, bf_vld, busy}),
            32'b0001_1100);
        chk({tag, "_addr"}, 32'({addr0_AMEM, addr1_AMEM, addr0_BMEM, addr1_BMEM,
                                 addr0_OMEM, addr1_OMEM, addr_CROM}), 0);
    endtask

    task automatic do_load(input bit gap);
        exp_t e;
        int base, t;
        base = n_load_wr;
        t = 0;
        while (!in_rdy && t < 50) begin @(posedge clk); #1; t++; end
        chk("in_rdy_at_load", in_rdy, 1);
        push_frame_exp();
        for (int j = 0; j < HALF; j++) begin
            if (gap) begin in_vld = 1'b0; @(posedge clk); #1; end
            e.mem = 0; e.a0 = 2 * j; e.a1 = 2 * j + 1; e.crom = 0;
            q_load.push_back(e);
            in_vld = 1'b1;
            @(posedge clk); #1;
        end
        in_vld = 1'b0;
        @(negedge clk);
        chk("busy_after_load", busy, 1);
        chk("sel_after_load", sel_input, 0);
        chk("in_rdy_after_load", in_rdy, 0);
        chk("load_writes", n_load_wr - base, HALF);
    endtask

    task automatic finish_frame(input int base);
        int t;
        t = 0;
        while (n_out_hs - base < HALF && t < 1000) begin @(posedge clk); t++; end
        chk("frame_pairs", n_out_hs - base, HALF);
        #1;
        chk("idle_in_rdy", in_rdy, 0);
        chk("idle_busy", busy, 0);
        chk("idle_out_vld", out_vld, 0);
        @(posedge clk); #1;
        chk("load_in_rdy", in_rdy, 1);
        chk("rd_left", q_rd.size(), 0);
        chk("wr_left", q_wr.size(), 0);
    endtask

    initial begin
        int base;
        rstn = 1'b0; in_vld = 1'b0;
        #12;
        chk_reset("por");
        @(posedge clk); #1 rstn = 1'b1;

        // Frame 1: back-to-back load, downstream randomly stalling.
        rdy_mode = 1;
        base = n_out_hs;
        do_load(1'b0);
        finish_frame(base);

        // Frame 2: gapped load, in_vld asserted during compute must be ignored.
        rdy_mode = 0;
        base = n_out_hs;
        do_load(1'b1);
        in_vld = 1'b1;
        repeat (10) @(posedge clk);
        #1 chk("in_rdy_compute", in_rdy, 0);
        in_vld = 1'b0;
        finish_frame(base);

        // Frame 3: aborted by reset in the middle of stage 2.
        do_load(1'b0);
        repeat (2 * (HALF + DLY) + 4) @(posedge clk);
        #3 rstn = 1'b0;
        #1 chk_reset("mid_rst");
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;

        // Frame 4: full frame after the abort.
        rdy_mode = 1;
        base = n_out_hs;
        do_load(1'b0);
        finish_frame(base);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
